lsu_stage: RTL

- Load/store stage directly downstream of the execute stage.
- Accepts one ex_lsu_t payload per transaction over a stage_if slave port.
- Performs at most one data-memory access over a valid/ready request/response bus: byte-lane alignment, store strobes, load sign/zero extension.
- Presents a registered write-back payload (lsu_wb_t) to the write-back stage over a stage_if master port.

---
 rtl/lsu_stage_if.sv | 16 +
 rtl/lsu_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage_if.sv
// Generic stage-to-stage handshake interface; the payload type is supplied
// per instance (ex_lsu_t from execute, lsu_wb_t towards write-back).

// Valid/ready: a transfer occurs on a rising clk edge where valid && ready.
// The master holds valid and payload steady until that edge and never waits
// on ready before raising valid; the slave may drive ready independently.
interface stage_if #(
  parameter type payload_t = logic
) ();
  logic     valid;
  logic     ready;
  payload_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: one data-memory access per instruction, registered write-back.
// Optional macro LSU_MISALIGN_CHECK_EN: trap misaligned half/word accesses instead of wrapping.
package lsu_pkg;
  typedef struct packed {
    logic [31:0] pc_target;
    logic [31:0] exu_result;
    logic        reg_wen;
    logic [4:0]  rd_addr;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [2:0]  funct3;
  } ex_lsu_t;

  typedef struct packed {
    logic [31:0] pc_target;
    logic [31:0] wb_data;
    logic        reg_wen;
    logic [4:0]  rd_addr;
  } lsu_wb_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_WB} lsu_state_e;
endpackage

module lsu_stage
  import lsu_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  stage_if.slave      lsu_in,
  stage_if.master     lsu_out,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_rdata,
  output logic        lsu_timeout,
  output logic        lsu_misalign,
  output lsu_state_e  dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  ex_lsu_t     in_p;
  lsu_wb_t     out_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        wen_q;
  logic [7:0]  cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        req_valid_q;
  logic        rsp_ready_q;
  logic        timeout_q;
  logic        misalign_q;
  logic        in_misalign;
  logic        tmo_hit;
  logic [7:0]  cnt_inc;
  logic [1:0]  off;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign in_p    = lsu_in.payload;
  assign off     = addr_q[1:0];
  assign tmo_hit = (cnt >= TMO_LAST);
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

`ifdef LSU_MISALIGN_CHECK_EN
  assign in_misalign = in_p.mem_en &&
                       ((in_p.funct3[1:0] == 2'b01 && in_p.mem_addr[0]) ||
                        (in_p.funct3[1:0] == 2'b10 && in_p.mem_addr[1:0] != 2'b00));
`else
  assign in_misalign = 1'b0;
`endif

  // Store lanes: data is replicated so the strobed lanes always carry it.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata_q;
    case (f3_q)
      3'b000: begin
        st_strb = 4'b0001 << off;
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        st_strb = 4'b0011 << {off[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shift = mem_rsp_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Every output flop is updated alongside the state it belongs to, so all
  // handshake outputs are pure functions of the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
      misalign_q  <= 1'b0;
      cnt         <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      wen_q       <= 1'b0;
      out_q       <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_in.valid && in_ready_q) begin
            in_ready_q      <= 1'b0;
            addr_q          <= in_p.mem_addr;
            wdata_q         <= in_p.mem_wdata;
            f3_q            <= in_p.funct3;
            wen_q           <= in_p.mem_wen;
            out_q.pc_target <= in_p.pc_target;
            out_q.rd_addr   <= in_p.rd_addr;
            out_q.wb_data   <= in_p.exu_result;
            out_q.reg_wen   <= in_p.reg_wen && !in_misalign;
            if (in_p.mem_en && !in_misalign) begin
              state       <= S_REQ;
              req_valid_q <= 1'b1;
              cnt         <= 8'd0;
            end else begin
              state       <= S_WB;
              out_valid_q <= 1'b1;
              misalign_q  <= in_misalign;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_REQ: begin
          cnt <= cnt_inc;
          // An accept in the expiry cycle still wins; the counter keeps running.
          if (mem_req_ready) begin
            state       <= S_RSP;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
          end else if (tmo_hit) begin
            state       <= S_WB;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            if (wen_q) out_q.reg_wen <= 1'b0;
            else       out_q.wb_data <= ERR_RDATA;
          end
        end
        S_RSP: begin
          cnt <= cnt_inc;
          if (mem_rsp_valid) begin
            state       <= S_WB;
            rsp_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            if (wen_q) out_q.reg_wen <= 1'b0;
            else       out_q.wb_data <= ld_data;
          end else if (tmo_hit) begin
            state       <= S_WB;
            rsp_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            if (wen_q) out_q.reg_wen <= 1'b0;
            else       out_q.wb_data <= ERR_RDATA;
          end
        end
        S_WB: begin
          if (lsu_out.ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_in.ready    = in_ready_q;
  assign lsu_out.valid   = out_valid_q;
  assign lsu_out.payload = out_q;
  assign mem_req_valid   = req_valid_q;
  assign mem_req_addr    = {addr_q[31:2], 2'b00};
  assign mem_req_wen     = wen_q;
  assign mem_req_wdata   = st_data;
  assign mem_req_wstrb   = wen_q ? st_strb : 4'b0000;
  assign mem_rsp_ready   = rsp_ready_q;
  assign lsu_timeout     = timeout_q;
  assign lsu_misalign    = misalign_q;
  assign dbg_state       = state;

endmodule
